// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: widths, ALU op codes, forwarding selects, control bundle.
// Latency: none, declarations and pure combinational helpers only.
// Backpressure: not applicable.
package rv32i_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ALUOP_W_DEF = 4;
    localparam int REG_IDX_W   = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // ALU operation encodings; ALU_ADD is the all-zero code carried by a bubble.
    typedef enum logic [ALUOP_W_DEF-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_SLL   = 4'h2,
        ALU_SLT   = 4'h3,
        ALU_SLTU  = 4'h4,
        ALU_XOR   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_OR    = 4'h8,
        ALU_AND   = 4'h9,
        ALU_PASSB = 4'hA
    } alu_op_e;

    // Operand forwarding selects: register file, EX/MEM result, MEM/WB result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Single-bit control signals travelling with the instruction.
    typedef struct packed {
        logic alu_src;     // ALU operand B: 0 = rs2_data, 1 = imm
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // An invalid slot must never write state or redirect fetch, so its
    // side-effecting bits are cleared; mux-select bits are left alone.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
        ctrl_t g;
        g = c;
        if (!valid) begin
            g.reg_write = 1'b0;
            g.mem_read  = 1'b0;
            g.mem_write = 1'b0;
            g.branch    = 1'b0;
        end
        return g;
    endfunction

    // Register index match that ignores x0, which is hard-wired to zero.
    function automatic logic idx_hit(input reg_idx_t src, input reg_idx_t rd);
        return (rd != '0) && (src == rd);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Picks the operand source for one ALU input from the EX/MEM and MEM/WB destinations.
// Latency: combinational, zero cycles.
// Backpressure: none; the enclosing pipeline register decides when the result is captured.
module fwd_sel
    import rv32i_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    input  logic [4:0] wb_rd,
    input  logic       wb_we,
    output logic [1:0] sel
);

    // Youngest producer wins: EX/MEM before MEM/WB, x0 never matches.
    always_comb begin
        sel = FWD_RF;
        if (mem_we && idx_hit(rs, mem_rd)) begin
            sel = FWD_MEM;
        end else if (wb_we && idx_hit(rs, wb_rd)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detect; optional forwarding selects under ID_EX_FWD_EN.
// Latency: one cycle id_* -> ex_*; load_use_hazard is combinational.
// Backpressure: stall holds all contents, flush loads a bubble and overrides stall.
module id_ex_reg
    import rv32i_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,

    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_branch,

`ifdef ID_EX_FWD_EN
    input  logic [4:0]         mem_rd,
    input  logic               mem_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic               wb_reg_write,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
`endif

    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,

    output logic               load_use_hazard
);

    localparam logic [ALUOP_W-1:0] ALU_OP_BUBBLE = ALUOP_W'(ALU_ADD);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    // Bundle the decoded control bits so they move through the register as one field.
    always_comb begin
        id_ctrl            = CTRL_BUBBLE;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.mem_read   = id_mem_read;
        id_ctrl.mem_write  = id_mem_write;
        id_ctrl.reg_write  = id_reg_write;
        id_ctrl.mem_to_reg = id_mem_to_reg;
        id_ctrl.branch     = id_branch;
    end

    // Pipeline register: reset clears, flush inserts a bubble (beats stall), stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_op   <= ALU_OP_BUBBLE;
            ex_ctrl     <= CTRL_BUBBLE;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_alu_op   <= ALU_OP_BUBBLE;
            ex_ctrl     <= CTRL_BUBBLE;
        end else if (!stall) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_alu_op   <= id_alu_op;
            ex_ctrl     <= gate_ctrl(id_ctrl, id_valid);
        end
    end

    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;

    // A load in EX whose destination is a source of the instruction in ID
    // cannot be forwarded in time; the pipeline controller stalls IF/ID and
    // flushes ID/EX in response. Nothing inside this block consumes it.
    always_comb begin
        load_use_hazard = ex_valid && ex_ctrl.mem_read && id_valid &&
                          (idx_hit(id_rs1, ex_rd) || idx_hit(id_rs2, ex_rd));
    end

`ifdef ID_EX_FWD_EN
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    fwd_sel u_fwd_a (
        .rs     (id_rs1),
        .mem_rd (mem_rd),
        .mem_we (mem_reg_write),
        .wb_rd  (wb_rd),
        .wb_we  (wb_reg_write),
        .sel    (fwd_a_nxt)
    );

    fwd_sel u_fwd_b (
        .rs     (id_rs2),
        .mem_rd (mem_rd),
        .mem_we (mem_reg_write),
        .wb_rd  (wb_rd),
        .wb_we  (wb_reg_write),
        .sel    (fwd_b_nxt)
    );

    // Forwarding selects follow the same reset/flush/stall rules as the other ex_* fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_fwd_a <= FWD_RF;
            ex_fwd_b <= FWD_RF;
        end else if (flush) begin
            ex_fwd_a <= FWD_RF;
            ex_fwd_b <= FWD_RF;
        end else if (!stall) begin
            ex_fwd_a <= fwd_a_nxt;
            ex_fwd_b <= fwd_b_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: table of capture/stall/flush vectors plus hand sequences.
// Latency: checks ex_* two time units after each rising edge.
// Backpressure: exercised through the stall and flush inputs.
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic        load_use_hazard;

`ifdef ID_EX_FWD_EN
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
`endif

    int checks   = 0;
    int failures = 0;

    id_ex_reg #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_op       (id_alu_op),
        .id_alu_src      (id_alu_src),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_reg_write    (id_reg_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_branch       (id_branch),
`ifdef ID_EX_FWD_EN
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_rd           (wb_rd),
        .wb_reg_write    (wb_reg_write),
        .ex_fwd_a        (ex_fwd_a),
        .ex_fwd_b        (ex_fwd_b),
`endif
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_alu_op       (ex_alu_op),
        .ex_alu_src      (ex_alu_src),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_branch       (ex_branch),
        .load_use_hazard (load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
    typedef struct {
        logic        stall, flush, valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic [5:0]  ctrl;
        logic        e_valid;
        logic [31:0] e_pc, e_a, e_b, e_imm;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [3:0]  e_op;
        logic [5:0]  e_ctrl;
    } vec_t;

    vec_t vec [9];

    function automatic logic [5:0] ex_ctrl_bits();
        return {ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] op,
                         input logic [5:0] ctrl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = a;
        id_rs2_data = b;
        id_imm      = imm;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_alu_op   = op;
        {id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch} = ctrl;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 6'b000000);
`ifdef ID_EX_FWD_EN
        mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
`endif

        //            st fl v  pc            a             b             imm           rs1    rs2    rd     op    ctrl        ev  e_pc          e_a           e_b           e_imm         e_rs1  e_rs2  e_rd   e_op  e_ctrl
        vec[0] = '{1'b0,1'b0,1'b1, 32'h10, 32'h1111, 32'h2222, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 4'h2, 6'b100000,
                   1'b1, 32'h10, 32'h1111, 32'h2222, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 4'h2, 6'b100000};
        vec[1] = '{1'b0,1'b0,1'b1, 32'h14, 32'h3333, 32'h4444, 32'h8, 5'd6, 5'd7, 5'd5, 4'h0, 6'b110110,
                   1'b1, 32'h14, 32'h3333, 32'h4444, 32'h8, 5'd6, 5'd7, 5'd5, 4'h0, 6'b110110};
        vec[2] = '{1'b0,1'b0,1'b0, 32'h18, 32'h5, 32'h6, 32'h4, 5'd8, 5'd9, 5'd10, 4'h1, 6'b111111,
                   1'b0, 32'h18, 32'h5, 32'h6, 32'h4, 5'd8, 5'd9, 5'd10, 4'h1, 6'b100010};
        vec[3] = '{1'b0,1'b0,1'b1, 32'h20, 32'h7, 32'h8, 32'hC, 5'd11, 5'd12, 5'd9, 4'h5, 6'b000101,
                   1'b1, 32'h20, 32'h7, 32'h8, 32'hC, 5'd11, 5'd12, 5'd9, 4'h5, 6'b000101};
        vec[4] = '{1'b1,1'b1,1'b1, 32'h30, 32'h9, 32'hA, 32'h10, 5'd13, 5'd14, 5'd7, 4'h6, 6'b000100,
                   1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 6'b000000};
        vec[5] = '{1'b0,1'b0,1'b1, 32'h40, 32'hB, 32'hC, 32'h14, 5'd15, 5'd16, 5'd11, 4'hF, 6'b001000,
                   1'b1, 32'h40, 32'hB, 32'hC, 32'h14, 5'd15, 5'd16, 5'd11, 4'hF, 6'b001000};
        vec[6] = '{1'b1,1'b0,1'b1, 32'h44, 32'hD, 32'hE, 32'h18, 5'd17, 5'd18, 5'd12, 4'h7, 6'b010110,
                   1'b1, 32'h40, 32'hB, 32'hC, 32'h14, 5'd15, 5'd16, 5'd11, 4'hF, 6'b001000};
        vec[7] = '{1'b0,1'b0,1'b1, 32'h48, 32'hF, 32'h10, 32'h1C, 5'd19, 5'd20, 5'd13, 4'h3, 6'b000100,
                   1'b1, 32'h48, 32'hF, 32'h10, 32'h1C, 5'd19, 5'd20, 5'd13, 4'h3, 6'b000100};
        vec[8] = '{1'b0,1'b1,1'b0, 32'h4C, 32'h11, 32'h12, 32'h20, 5'd21, 5'd22, 5'd14, 4'h4, 6'b110110,
                   1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'h0, 6'b000000};

        // Reset state, including across a clock edge.
        step();
        chk("rst_valid", 64'(ex_valid), 64'h0);
        chk("rst_pc",    64'(ex_pc),    64'h0);
        chk("rst_imm",   64'(ex_imm),   64'h0);
        chk("rst_rd",    64'(ex_rd),    64'h0);
        chk("rst_op",    64'(ex_alu_op), 64'h0);
        chk("rst_ctrl",  64'(ex_ctrl_bits()), 64'h0);
        chk("rst_haz",   64'(load_use_hazard), 64'h0);
        rst_n = 1'b1;

        // Table: apply, one edge, compare.
        for (int i = 0; i < 9; i++) begin
            stall = vec[i].stall;
            flush = vec[i].flush;
            drive(vec[i].valid, vec[i].pc, vec[i].a, vec[i].b, vec[i].imm,
                  vec[i].rs1, vec[i].rs2, vec[i].rd, vec[i].op, vec[i].ctrl);
            step();
            chk($sformatf("v%0d_valid", i), 64'(ex_valid),    64'(vec[i].e_valid));
            chk($sformatf("v%0d_pc", i),    64'(ex_pc),       64'(vec[i].e_pc));
            chk($sformatf("v%0d_a", i),     64'(ex_rs1_data), 64'(vec[i].e_a));
            chk($sformatf("v%0d_b", i),     64'(ex_rs2_data), 64'(vec[i].e_b));
            chk($sformatf("v%0d_imm", i),   64'(ex_imm),      64'(vec[i].e_imm));
            chk($sformatf("v%0d_rs1", i),   64'(ex_rs1),      64'(vec[i].e_rs1));
            chk($sformatf("v%0d_rs2", i),   64'(ex_rs2),      64'(vec[i].e_rs2));
            chk($sformatf("v%0d_rd", i),    64'(ex_rd),       64'(vec[i].e_rd));
            chk($sformatf("v%0d_op", i),    64'(ex_alu_op),   64'(vec[i].e_op));
            chk($sformatf("v%0d_ctrl", i),  64'(ex_ctrl_bits()), 64'(vec[i].e_ctrl));
        end
        stall = 1'b0;
        flush = 1'b0;

        // Stall held three cycles while ID keeps changing, then release.
        drive(1'b1, 32'h100, 32'h1, 32'h2, 32'h50, 5'd1, 5'd2, 5'd21, 4'h8, 6'b000100);
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h104 + 32'(4 * k), 32'h9, 32'h9, 32'h9, 5'd3, 5'd4, 5'(22 + k), 4'h1, 6'b010110);
            step();
            chk($sformatf("stall%0d_pc", k),   64'(ex_pc),   64'h100);
            chk($sformatf("stall%0d_rd", k),   64'(ex_rd),   64'd21);
            chk($sformatf("stall%0d_ctrl", k), 64'(ex_ctrl_bits()), 64'b000100);
        end
        stall = 1'b0;
        drive(1'b1, 32'h200, 32'h3, 32'h4, 32'h60, 5'd5, 5'd6, 5'd30, 4'h9, 6'b000100);
        step();
        chk("unstall_pc", 64'(ex_pc), 64'h200);
        chk("unstall_rd", 64'(ex_rd), 64'd30);

        // Load-use hazard: load to x5 in EX, probe ID sources with the register held.
        drive(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 4'h0, 6'b110110);
        step();
        stall = 1'b1;
        id_rs1 = 5'd1; id_rs2 = 5'd5; #1;
        chk("haz_rs2", 64'(load_use_hazard), 64'h1);
        id_rs1 = 5'd5; id_rs2 = 5'd0; #1;
        chk("haz_rs1", 64'(load_use_hazard), 64'h1);
        id_valid = 1'b0; #1;
        chk("haz_id_invalid", 64'(load_use_hazard), 64'h0);
        id_valid = 1'b1; id_rs1 = 5'd4; id_rs2 = 5'd6; #1;
        chk("haz_nomatch", 64'(load_use_hazard), 64'h0);
        stall = 1'b0;
        drive(1'b1, 32'h304, 32'h0, 32'h0, 32'h0, 5'd4, 5'd6, 5'd0, 4'h0, 6'b110110);
        step();
        stall = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
        chk("haz_x0", 64'(load_use_hazard), 64'h0);
        stall = 1'b0;
        drive(1'b1, 32'h308, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 4'h0, 6'b000100);
        step();
        stall = 1'b1;
        id_rs2 = 5'd5; #1;
        chk("haz_not_load", 64'(load_use_hazard), 64'h0);
        stall = 1'b0;

        // Asynchronous reset mid-cycle with a valid instruction in EX.
        drive(1'b1, 32'h60, 32'h7, 32'h8, 32'h24, 5'd2, 5'd3, 5'd4, 4'h5, 6'b000100);
        step();
        chk("pre_rst_valid", 64'(ex_valid), 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ex_valid), 64'h0);
        chk("arst_pc",    64'(ex_pc),    64'h0);
        chk("arst_rd",    64'(ex_rd),    64'h0);
        chk("arst_b",     64'(ex_rs2_data), 64'h0);
        chk("arst_ctrl",  64'(ex_ctrl_bits()), 64'h0);
        step();
        chk("rst_hold_valid", 64'(ex_valid), 64'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_pc",    64'(ex_pc),    64'h60);
        chk("post_rst_valid", 64'(ex_valid), 64'h1);

        // Reset during a stall discards the held instruction.
        stall = 1'b1;
        drive(1'b1, 32'h70, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd8, 4'h1, 6'b000100);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        chk("rst_stall_valid", 64'(ex_valid), 64'h0);
        chk("rst_stall_pc",    64'(ex_pc),    64'h0);
        stall = 1'b0;
        step();
        chk("rst_stall_resume", 64'(ex_pc), 64'h70);

`ifdef ID_EX_FWD_EN
        // Forwarding selects: EX/MEM priority, WB only, x0 ignored, flush clears.
        drive(1'b1, 32'h80, 32'h0, 32'h0, 32'h0, 5'd7, 5'd3, 5'd1, 4'h0, 6'b000100);
        mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd7; wb_reg_write = 1'b1;
        step();
        chk("fwd_a_mem", 64'(ex_fwd_a), 64'h2);
        chk("fwd_b_rf",  64'(ex_fwd_b), 64'h0);
        mem_reg_write = 1'b0;
        step();
        chk("fwd_a_wb", 64'(ex_fwd_a), 64'h1);
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd9;
        id_rs1 = 5'd0;
        step();
        chk("fwd_a_x0", 64'(ex_fwd_a), 64'h0);
        id_rs1 = 5'd7; wb_rd = 5'd7; id_rs2 = 5'd7;
        step();
        chk("fwd_b_wb", 64'(ex_fwd_b), 64'h1);
        flush = 1'b1;
        step();
        chk("fwd_flush", 64'({ex_fwd_a, ex_fwd_b}), 64'h0);
        flush = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
